// File: rtl/md_pkg.sv
// md_pkg: shared definitions for the multiply/divide unit.
//   - md_op_e   : 4-bit operation encoding driven on md_unit.op
//   - MD_OP_W   : operation code width
//   - default busy durations for multiply-class and divide-class ops
//   - FSM state and accumulate-mode encodings used inside md_unit
// The multiply-accumulate codes (MADD..MSUBU) are only acted on when the
// design is built with MD_MADD_EN defined; otherwise they decode as no-ops.
package md_pkg;

  localparam int MD_OP_W            = 4;
  localparam int MD_MULT_CYCLES_DEF = 5;
  localparam int MD_DIV_CYCLES_DEF  = 10;

  typedef enum logic [MD_OP_W-1:0] {
    MD_NONE = 4'd0,
    MULT    = 4'd1,
    MULTU   = 4'd2,
    DIV     = 4'd3,
    DIVU    = 4'd4,
    MTHI    = 4'd5,
    MTLO    = 4'd6,
    MADD    = 4'd7,
    MADDU   = 4'd8,
    MSUB    = 4'd9,
    MSUBU   = 4'd10
  } md_op_e;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } md_state_e;

  // How the pending value is merged into {HI,LO} at commit.
  typedef enum logic [1:0] {
    ACC_NONE = 2'd0,  // overwrite
    ACC_ADD  = 2'd1,  // {HI,LO} + pending
    ACC_SUB  = 2'd2   // {HI,LO} - pending
  } md_acc_e;

endpackage

// File: rtl/md_calc.sv
// md_calc: combinational arithmetic for md_unit.
// Ports:
//   op       in  4   operation code (md_pkg::md_op_e)
//   A        in  32  RS operand (multiplicand / dividend)
//   B        in  32  RT operand (multiplier / divisor)
//   res      out 64  {HI,LO} result: product, or {remainder, quotient}
//   div_zero out 1   divide op with B == 0 (result must not be committed)
// Config macro: MD_MADD_EN adds MADD/MADDU/MSUB/MSUBU, which produce the
// plain product here; the accumulate step happens at commit in md_unit.
module md_calc
  import md_pkg::*;
(
  input  logic [MD_OP_W-1:0] op,
  input  logic [31:0]        A,
  input  logic [31:0]        B,
  output logic [63:0]        res,
  output logic               div_zero
);

  // One shared multiplier: operands are sign- or zero-extended to 64 bits,
  // and the low 64 bits of the 64x64 product are the exact 32x32 result.
  logic        mul_signed;
  logic [63:0] mul_a;
  logic [63:0] mul_b;
  logic [63:0] product;

  always_comb begin
    mul_signed = 1'b0;
    case (op)
      MULT:    mul_signed = 1'b1;
`ifdef MD_MADD_EN
      MADD,
      MSUB:    mul_signed = 1'b1;
`endif
      default: mul_signed = 1'b0;
    endcase
  end

  assign mul_a   = {{32{mul_signed & A[31]}}, A};
  assign mul_b   = {{32{mul_signed & B[31]}}, B};
  assign product = mul_a * mul_b;

  // One shared unsigned divider on magnitudes. Signed DIV fixes signs
  // afterwards: quotient negative when operand signs differ (truncation
  // toward zero), remainder follows the dividend. 0x80000000 / -1 falls out
  // naturally: magnitude quotient 0x80000000, negated, wraps to itself.
  logic        div_signed;
  logic [31:0] dvd_mag;
  logic [31:0] dvs_mag;
  logic [31:0] dvs_safe;
  logic [31:0] q_mag;
  logic [31:0] r_mag;
  logic [31:0] quot;
  logic [31:0] rem;

  assign div_signed = (op == MD_OP_W'(DIV));
  assign dvd_mag    = (div_signed && A[31]) ? (32'd0 - A) : A;
  assign dvs_mag    = (div_signed && B[31]) ? (32'd0 - B) : B;
  // Keep the divider defined for B == 0; that result is never committed.
  assign dvs_safe   = (dvs_mag == 32'd0) ? 32'd1 : dvs_mag;
  assign q_mag      = dvd_mag / dvs_safe;
  assign r_mag      = dvd_mag % dvs_safe;
  assign quot       = (div_signed && (A[31] ^ B[31])) ? (32'd0 - q_mag) : q_mag;
  assign rem        = (div_signed && A[31]) ? (32'd0 - r_mag) : r_mag;

  always_comb begin
    res      = 64'd0;
    div_zero = 1'b0;
    case (op)
      MULT,
      MULTU: res = product;
`ifdef MD_MADD_EN
      MADD,
      MADDU,
      MSUB,
      MSUBU: res = product;
`endif
      DIV,
      DIVU: begin
        res      = {rem, quot};
        div_zero = (B == 32'd0);
      end
      default: res = 64'd0;
    endcase
  end

endmodule

// File: rtl/md_unit.sv
// md_unit: EX-stage multiply/divide unit owning HI/LO.
// Ports:
//   clk   in  1   pipeline clock, rising edge
//   rst   in  1   asynchronous active-low reset
//   start in  1   qualifies op this cycle
//   op    in  4   operation code (md_pkg::md_op_e)
//   A     in  32  forwarded RS value
//   B     in  32  forwarded RT value
//   busy  out 1   operation in flight (registered)
//   HI    out 32  HI register
//   LO    out 32  LO register
// Parameters: MULT_CYCLES / DIV_CYCLES set the busy duration per op class.
// Config macro: MD_MADD_EN enables MADD/MADDU/MSUB/MSUBU, which add or
// subtract the product into the {HI,LO} value present at commit.
// The result is computed when start is accepted and parked in pending
// registers; the counter only models latency, committing at its 1->0 step.
module md_unit
  import md_pkg::*;
#(
  parameter int MULT_CYCLES = MD_MULT_CYCLES_DEF,
  parameter int DIV_CYCLES  = MD_DIV_CYCLES_DEF
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [MD_OP_W-1:0] op,
  input  logic [31:0]        A,
  input  logic [31:0]        B,
  output logic               busy,
  output logic [31:0]        HI,
  output logic [31:0]        LO
);

  localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int CNT_W      = $clog2(MAX_CYCLES + 1);

  logic [63:0] calc_res;
  logic        calc_dz;

  md_calc u_calc (
    .op       (op),
    .A        (A),
    .B        (B),
    .res      (calc_res),
    .div_zero (calc_dz)
  );

  md_state_e   state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [63:0] pend_q, pend_d;
  logic        dz_q, dz_d;
  logic [31:0] hi_q, hi_d;
  logic [31:0] lo_q, lo_d;
`ifdef MD_MADD_EN
  md_acc_e     acc_q, acc_d;
  logic [63:0] hilo_cur;
  assign hilo_cur = {hi_q, lo_q};
`endif

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    pend_d  = pend_q;
    dz_d    = dz_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
`ifdef MD_MADD_EN
    acc_d   = acc_q;
`endif
    case (state_q)
      IDLE: begin
        if (start) begin
          case (op)
            MULT,
            MULTU: begin
              pend_d  = calc_res;
              dz_d    = 1'b0;
              cnt_d   = CNT_W'(MULT_CYCLES);
              state_d = RUN;
`ifdef MD_MADD_EN
              acc_d   = ACC_NONE;
`endif
            end
            DIV,
            DIVU: begin
              pend_d  = calc_res;
              dz_d    = calc_dz;
              cnt_d   = CNT_W'(DIV_CYCLES);
              state_d = RUN;
`ifdef MD_MADD_EN
              acc_d   = ACC_NONE;
`endif
            end
            MTHI: hi_d = A;
            MTLO: lo_d = A;
`ifdef MD_MADD_EN
            MADD,
            MADDU: begin
              pend_d  = calc_res;
              dz_d    = 1'b0;
              cnt_d   = CNT_W'(MULT_CYCLES);
              state_d = RUN;
              acc_d   = ACC_ADD;
            end
            MSUB,
            MSUBU: begin
              pend_d  = calc_res;
              dz_d    = 1'b0;
              cnt_d   = CNT_W'(MULT_CYCLES);
              state_d = RUN;
              acc_d   = ACC_SUB;
            end
`endif
            default: ;  // MD_NONE and undefined codes do nothing
          endcase
        end
      end
      RUN: begin
        // start is deliberately ignored here.
        cnt_d = cnt_q - CNT_W'(1);
        if (cnt_q <= CNT_W'(1)) begin
          cnt_d   = '0;
          state_d = IDLE;
          if (!dz_q) begin
`ifdef MD_MADD_EN
            case (acc_q)
              ACC_ADD: {hi_d, lo_d} = hilo_cur + pend_q;
              ACC_SUB: {hi_d, lo_d} = hilo_cur - pend_q;
              default: {hi_d, lo_d} = pend_q;
            endcase
`else
            {hi_d, lo_d} = pend_q;
`endif
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      pend_q  <= '0;
      dz_q    <= 1'b0;
      hi_q    <= '0;
      lo_q    <= '0;
`ifdef MD_MADD_EN
      acc_q   <= ACC_NONE;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      pend_q  <= pend_d;
      dz_q    <= dz_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
`ifdef MD_MADD_EN
      acc_q   <= acc_d;
`endif
    end
  end

  assign busy = (state_q == RUN);
  assign HI   = hi_q;
  assign LO   = lo_q;

endmodule
